spell_mem_param: RTL and testbench

Parametrised successor to the SPELL CPU's flip-flop scratch memory. It holds separate code and data banks with independent depths and word width, and a compile-time access latency. It uses a select/ready handshake that holds the result until the CPU releases select. A post-reset clear sweep zeroes both banks, and an address-error flag is raised for out-of-range accesses. It sits between the SPELL core's memory port and the other memory back-ends as a drop-in, simulation-friendly, synthesisable store.

---
 rtl/spell_mem_pkg.sv | 23 ++
 rtl/spell_mem_param_if.sv | 42 ++++
 rtl/spell_mem_bank.sv | 32 +++
 rtl/spell_mem_param.sv | 150 +++++++++++++++
 tb/tb_spell_mem_param.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spell_mem_pkg.sv
// Shared types and helpers for the parametrised SPELL scratch memory.
// Holds the controller state encoding, bank-select codes and sizing functions.
package spell_mem_pkg;

   typedef enum logic [1:0] {
      StClear,
      StWait,
      StDone
   } state_e;

   localparam logic BANK_CODE = 1'b0;
   localparam logic BANK_DATA = 1'b1;

   function automatic int unsigned max_depth(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Clear pointer needs at least one bit even for single-word banks.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/spell_mem_param_if.sv
// CPU-side select/ready memory port of the SPELL scratch memory.
// The CPU drives the master modport; the memory implements the slave modport.
interface spell_mem_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) ();

   logic              select;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic              memory_type_data;
   logic              write;
   logic [DATA_W-1:0] data_out;
   logic              data_ready;
   logic              addr_error;
   logic              init_done;

   modport master (
      output select,
      output addr,
      output data_in,
      output memory_type_data,
      output write,
      input  data_out,
      input  data_ready,
      input  addr_error,
      input  init_done
   );

   modport slave (
      input  select,
      input  addr,
      input  data_in,
      input  memory_type_data,
      input  write,
      output data_out,
      output data_ready,
      output addr_error,
      output init_done
   );

endinterface

// File: rtl/spell_mem_bank.sv
// One flip-flop memory bank: synchronous write, combinational read.
// Out-of-range addresses read as zero and never write.
module spell_mem_bank #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              in_range_o
);

   localparam int unsigned IdxW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IdxW-1:0]   idx;

   assign idx        = addr_i[IdxW-1:0];
   assign in_range_o = {1'b0, addr_i} < (ADDR_W + 1)'(DEPTH);
   // Gate the read so a non-power-of-two depth never indexes past the array.
   assign rdata_o    = in_range_o ? mem_q[idx] : '0;

   always_ff @(posedge clk_i) begin
      if (we_i && in_range_o) begin
         mem_q[idx] <= wdata_i;
      end
   end

endmodule

// File: rtl/spell_mem_param.sv
// Parametrised SPELL scratch memory: code and data banks behind a select/ready
// handshake, with a post-reset zeroing sweep and an out-of-range error flag.
module spell_mem_param
   import spell_mem_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned CODE_DEPTH = 32,
   parameter int unsigned DATA_DEPTH = 8,
   parameter int unsigned LATENCY    = 0
) (
   input  logic             clk,
   input  logic             rst,
   spell_mem_param_if.slave mem_if
);

   localparam int unsigned MaxDepth = max_depth(CODE_DEPTH, DATA_DEPTH);
   localparam int unsigned PtrW     = ptr_width(MaxDepth);
   localparam logic [3:0]  LatInit  = 4'(LATENCY);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxDepth - 1);

   state_e            state_q, state_d;
   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_ready_q, data_ready_d;
   logic              addr_error_q, addr_error_d;
   logic              init_done_q, init_done_d;

   logic [ADDR_W-1:0] bank_addr;
   logic [DATA_W-1:0] bank_wdata;
   logic              code_we, data_we;
   logic [DATA_W-1:0] code_rdata, data_rdata;
   logic              code_in_range, data_in_range;
   logic              sel_data, sel_in_range;
   logic [DATA_W-1:0] sel_rdata;

   spell_mem_bank #(
      .DEPTH  (CODE_DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_code_bank (
      .clk_i      (clk),
      .we_i       (code_we),
      .addr_i     (bank_addr),
      .wdata_i    (bank_wdata),
      .rdata_o    (code_rdata),
      .in_range_o (code_in_range)
   );

   spell_mem_bank #(
      .DEPTH  (DATA_DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_data_bank (
      .clk_i      (clk),
      .we_i       (data_we),
      .addr_i     (bank_addr),
      .wdata_i    (bank_wdata),
      .rdata_o    (data_rdata),
      .in_range_o (data_in_range)
   );

   assign sel_data     = (mem_if.memory_type_data == BANK_DATA);
   assign sel_in_range = sel_data ? data_in_range : code_in_range;
   assign sel_rdata    = sel_data ? data_rdata : code_rdata;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      data_out_d   = data_out_q;
      data_ready_d = data_ready_q;
      addr_error_d = addr_error_q;
      init_done_d  = init_done_q;
      bank_addr    = mem_if.addr;
      bank_wdata   = mem_if.data_in;
      code_we      = 1'b0;
      data_we      = 1'b0;

      case (state_q)
         StClear: begin
            // The sweep shares the bank address port; select is ignored here.
            bank_addr  = ADDR_W'(ptr_q);
            bank_wdata = '0;
            code_we    = 32'(ptr_q) < CODE_DEPTH;
            data_we    = 32'(ptr_q) < DATA_DEPTH;
            ptr_d      = ptr_q + PtrW'(1);
            if (ptr_q == PtrLast) begin
               state_d     = StWait;
               init_done_d = 1'b1;
            end
         end
         StWait: begin
            if (!mem_if.select) begin
               cnt_d        = LatInit;
               data_ready_d = 1'b0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d      = StDone;
               data_ready_d = 1'b1;
               addr_error_d = !sel_in_range;
               if (mem_if.write) begin
                  code_we = !sel_data && code_in_range;
                  data_we = sel_data && data_in_range;
               end else begin
                  data_out_d = sel_in_range ? sel_rdata : '0;
               end
            end
         end
         StDone: begin
            if (!mem_if.select) begin
               data_ready_d = 1'b0;
               cnt_d        = LatInit;
               state_d      = StWait;
            end
         end
         default: begin
            state_d = StClear;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StClear;
         ptr_q        <= '0;
         cnt_q        <= LatInit;
         data_out_q   <= '0;
         data_ready_q <= 1'b0;
         addr_error_q <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         data_ready_q <= data_ready_d;
         addr_error_q <= addr_error_d;
         init_done_q  <= init_done_d;
      end
   end

   assign mem_if.data_out   = data_out_q;
   assign mem_if.data_ready = data_ready_q;
   assign mem_if.addr_error = addr_error_q;
   assign mem_if.init_done  = init_done_q;

endmodule

// File: tb/tb_spell_mem_param.sv
// Bench for spell_mem_param: three instances (LATENCY 0, 3, 2) driven through
// indexed signal arrays, with a bank model feeding an expected-result queue.
module tb_spell_mem_param;

   typedef struct {
      string      tag;
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v;
   logic [2:0] sel;
   logic [2:0] wr;
   logic [2:0] mtd;
   logic [7:0] addr_v [3];
   logic [7:0] din_v  [3];
   logic [7:0] dout   [3];
   logic       rdy    [3];
   logic       err_o  [3];
   logic       done   [3];

   logic [7:0] code_m   [3][32];
   logic [7:0] data_m   [3][8];
   logic [7:0] last_out [3];
   exp_t       sb [$];

   int n_tests = 0;
   int n_fail  = 0;

   spell_mem_param_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
   spell_mem_param_if #(.DATA_W(8), .ADDR_W(8)) if1 ();
   spell_mem_param_if #(.DATA_W(8), .ADDR_W(8)) if2 ();

   spell_mem_param #(.LATENCY(0)) u_dut0 (.clk(clk), .rst(rst_v[0]), .mem_if(if0));
   spell_mem_param #(.LATENCY(3)) u_dut1 (.clk(clk), .rst(rst_v[1]), .mem_if(if1));
   spell_mem_param #(.LATENCY(2)) u_dut2 (.clk(clk), .rst(rst_v[2]), .mem_if(if2));

   assign if0.select = sel[0];
   assign if0.write = wr[0];
   assign if0.memory_type_data = mtd[0];
   assign if0.addr = addr_v[0];
   assign if0.data_in = din_v[0];
   assign if1.select = sel[1];
   assign if1.write = wr[1];
   assign if1.memory_type_data = mtd[1];
   assign if1.addr = addr_v[1];
   assign if1.data_in = din_v[1];
   assign if2.select = sel[2];
   assign if2.write = wr[2];
   assign if2.memory_type_data = mtd[2];
   assign if2.addr = addr_v[2];
   assign if2.data_in = din_v[2];

   assign dout[0] = if0.data_out;
   assign rdy[0] = if0.data_ready;
   assign err_o[0] = if0.addr_error;
   assign done[0] = if0.init_done;
   assign dout[1] = if1.data_out;
   assign rdy[1] = if1.data_ready;
   assign err_o[1] = if1.addr_error;
   assign done[1] = if1.init_done;
   assign dout[2] = if2.data_out;
   assign rdy[2] = if2.data_ready;
   assign err_o[2] = if2.addr_error;
   assign done[2] = if2.init_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse reset, hold select through the sweep and time init_done.
   task automatic sweep(input int d, input string tag);
      int n;
      bit seen;
      rst_v[d] = 1'b1;
      @(negedge clk);
      rst_v[d]  = 1'b0;
      wr[d]     = 1'b0;
      mtd[d]    = 1'b0;
      addr_v[d] = 8'd0;
      sel[d]    = 1'b1;
      n = 0;
      seen = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (rdy[d] === 1'b1) seen = 1'b1;
      end while (done[d] !== 1'b1 && n < 100);
      sel[d] = 1'b0;
      check({tag, "_len"}, 32'(n), 32'd32);
      check({tag, "_no_rdy"}, 32'(seen), 32'd0);
      for (int i = 0; i < 32; i++) code_m[d][i] = 8'h00;
      for (int i = 0; i < 8; i++) data_m[d][i] = 8'h00;
      last_out[d] = 8'h00;
      @(negedge clk);
   endtask

   task automatic do_access(input int d, input logic w, input logic bank, input logic [7:0] a,
                            input logic [7:0] din, input int lat, input string tag);
      exp_t e;
      int n;
      e.tag = tag;
      e.err = bank ? (a >= 8'd8) : (a >= 8'd32);
      if (w) begin
         e.data = last_out[d];
         if (!e.err) begin
            if (bank) data_m[d][a[2:0]] = din;
            else code_m[d][a[4:0]] = din;
         end
      end else begin
         if (e.err) e.data = 8'h00;
         else e.data = bank ? data_m[d][a[2:0]] : code_m[d][a[4:0]];
         last_out[d] = e.data;
      end
      sb.push_back(e);
      wr[d] = w;
      mtd[d] = bank;
      addr_v[d] = a;
      din_v[d] = din;
      sel[d] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[d] !== 1'b1 && n < 40);
      check({tag, "_lat"}, 32'(n), 32'(lat));
      e = sb.pop_front();
      check({e.tag, "_data"}, 32'(dout[d]), 32'(e.data));
      check({e.tag, "_err"}, 32'(err_o[d]), 32'(e.err));
   endtask

   task automatic release_sel(input int d, input string tag);
      sel[d] = 1'b0;
      @(negedge clk);
      check({tag, "_rel"}, 32'(rdy[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_v = 3'b111;
      sel = '0;
      wr = '0;
      mtd = '0;
      for (int i = 0; i < 3; i++) begin
         addr_v[i] = 8'd0;
         din_v[i] = 8'd0;
         last_out[i] = 8'd0;
      end
      #1;
      check("rst_dout", 32'(dout[0]), 32'd0);
      check("rst_rdy", 32'(rdy[0]), 32'd0);
      check("rst_err", 32'(err_o[0]), 32'd0);
      check("rst_done", 32'(done[0]), 32'd0);
      @(negedge clk);

      sweep(0, "sweep0");
      sweep(1, "sweep1");
      sweep(2, "sweep2");

      // LATENCY=0: basic reads/writes and bank independence.
      do_access(0, 1'b0, 1'b0, 8'd5, 8'h00, 1, "rd_code5");
      release_sel(0, "rd_code5");
      do_access(0, 1'b0, 1'b1, 8'd7, 8'h00, 1, "rd_data7");
      release_sel(0, "rd_data7");
      do_access(0, 1'b1, 1'b1, 8'd3, 8'hA5, 1, "wr_data3");
      release_sel(0, "wr_data3");
      do_access(0, 1'b0, 1'b1, 8'd3, 8'h00, 1, "rd_data3");
      release_sel(0, "rd_data3");
      do_access(0, 1'b0, 1'b0, 8'd3, 8'h00, 1, "rd_code3");
      release_sel(0, "rd_code3");

      // Out-of-range accesses.
      do_access(0, 1'b1, 1'b1, 8'd8, 8'hFF, 1, "oor_wr_data8");
      release_sel(0, "oor_wr_data8");
      do_access(0, 1'b0, 1'b1, 8'd0, 8'h00, 1, "rd_data0_after_oor");
      release_sel(0, "rd_data0_after_oor");
      do_access(0, 1'b0, 1'b0, 8'd40, 8'h00, 1, "oor_rd_code40");
      release_sel(0, "oor_rd_code40");

      // Handshake hold: outputs stay put while select is high, addr change ignored.
      do_access(0, 1'b0, 1'b1, 8'd3, 8'h00, 1, "hold_rd_data3");
      for (int i = 0; i < 5; i++) begin
         if (i == 2) addr_v[0] = 8'd5;
         @(negedge clk);
         check($sformatf("hold%0d_rdy", i), 32'(rdy[0]), 32'd1);
         check($sformatf("hold%0d_dout", i), 32'(dout[0]), 32'hA5);
      end
      release_sel(0, "hold");

      // LATENCY=3: full count, then an aborted write.
      do_access(1, 1'b1, 1'b1, 8'd2, 8'h5A, 4, "l3_wr_data2");
      release_sel(1, "l3_wr_data2");
      wr[1] = 1'b1;
      mtd[1] = 1'b0;
      addr_v[1] = 8'd1;
      din_v[1] = 8'h3C;
      sel[1] = 1'b1;
      @(negedge clk);
      check("abort_c1_rdy", 32'(rdy[1]), 32'd0);
      @(negedge clk);
      check("abort_c2_rdy", 32'(rdy[1]), 32'd0);
      sel[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_idle_rdy", 32'(rdy[1]), 32'd0);
      do_access(1, 1'b0, 1'b0, 8'd1, 8'h00, 4, "l3_rd_code1");
      release_sel(1, "l3_rd_code1");
      do_access(1, 1'b0, 1'b1, 8'd2, 8'h00, 4, "l3_rd_data2");
      release_sel(1, "l3_rd_data2");

      // LATENCY=2: asynchronous reset during the WAIT count of a write.
      do_access(2, 1'b1, 1'b1, 8'd0, 8'h11, 3, "l2_wr_data0");
      release_sel(2, "l2_wr_data0");
      do_access(2, 1'b0, 1'b1, 8'd0, 8'h00, 3, "l2_rd_data0");
      release_sel(2, "l2_rd_data0");
      wr[2] = 1'b1;
      mtd[2] = 1'b1;
      addr_v[2] = 8'd0;
      din_v[2] = 8'h77;
      sel[2] = 1'b1;
      @(posedge clk);
      #2;
      rst_v[2] = 1'b1;
      #1;
      check("arst_dout", 32'(dout[2]), 32'd0);
      check("arst_rdy", 32'(rdy[2]), 32'd0);
      check("arst_err", 32'(err_o[2]), 32'd0);
      check("arst_done", 32'(done[2]), 32'd0);
      sel[2] = 1'b0;
      @(negedge clk);
      sweep(2, "sweep2b");
      do_access(2, 1'b0, 1'b1, 8'd0, 8'h00, 3, "l2_rd_data0_after_rst");
      release_sel(2, "l2_rd_data0_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
